// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner, multi-byte fetch, branch/reti/vectored IRQ sequencing.
// Define FETCH_SEQ_LEVEL_IRQ_EN for level-sensitive interrupt requests (default: edge-latched).
module fetch_sequencer #(
  parameter int ADDR_BITS = 8,
  parameter int INSTR_BYTES = 2,
  parameter int NUM_IRQ = 4,
  parameter logic [ADDR_BITS-1:0] ISR_BASE = ADDR_BITS'(8'hF0),
  parameter logic [ADDR_BITS-1:0] ISR_STRIDE = ADDR_BITS'(8'h08)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     rd_ram_en,
  output logic [ADDR_BITS-1:0]     rd_ram_addr,
  input  logic [7:0]               rd_ram_data,
  output logic [8*INSTR_BYTES-1:0] ir,
  output logic                     ir_valid,
  input  logic                     exec_done,
  input  logic                     branch_en,
  input  logic [ADDR_BITS-1:0]     branch_target,
  input  logic                     reti,
  input  logic                     int_en_set,
  input  logic                     int_en_clr,
  input  logic [NUM_IRQ-1:0]       int_req,
  output logic [NUM_IRQ-1:0]       int_ack,
  output logic [ADDR_BITS-1:0]     pc,
  output logic                     in_isr,
  output logic                     int_enabled
);
  localparam int KW = INSTR_BYTES > 1 ? $clog2(INSTR_BYTES) : 1;
  localparam int IW = 8 * INSTR_BYTES;
  typedef enum logic [1:0] {IDLE, FETCH, LAST, EXEC} state_t;
  state_t state, state_d;
  logic [KW-1:0] k, k_d;
  logic [ADDR_BITS-1:0] saved_pc, candidate, vec;
  logic [NUM_IRQ-1:0] pending, clr;
  logic [3:0] irq_idx;
  logic boundary, do_reti, take, cap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
    end else begin
      state <= state_d;
      k <= k_d;
    end
  end

  always_comb begin
    state_d = state;
    k_d = k;
    case (state)
      IDLE: begin
        state_d = FETCH;
        k_d = '0;
      end
      FETCH: if (k == KW'(INSTR_BYTES - 1)) state_d = LAST; else k_d = k + 1'b1;
      LAST: state_d = EXEC;
      EXEC: if (exec_done) begin
        state_d = FETCH;
        k_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_ram_en = state == FETCH;
  assign rd_ram_addr = pc + ADDR_BITS'(k);
  assign ir_valid = state == EXEC;
  // each byte arrives the cycle after its request, lowest address first
  assign cap = (state == FETCH && k != '0) || state == LAST;
  assign boundary = state == EXEC && exec_done;
  assign do_reti = boundary && reti && in_isr;
  assign take = boundary && int_enabled && !in_isr && |pending;
  assign candidate = branch_en ? branch_target : pc + ADDR_BITS'(INSTR_BYTES);
  assign clr = take ? NUM_IRQ'(1) << irq_idx : '0;
  assign vec = ISR_BASE + ADDR_BITS'(irq_idx) * ISR_STRIDE;

  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pending[i]) irq_idx = 4'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      saved_pc <= '0;
      in_isr <= 1'b0;
      int_enabled <= 1'b0;
      int_ack <= '0;
      ir <= '0;
    end else begin
      int_ack <= clr;
      if (cap) ir <= IW'({ir, rd_ram_data});
      if (boundary) begin
        pc <= do_reti ? saved_pc : take ? vec : candidate;
        if (do_reti || take) in_isr <= take;
        int_enabled <= do_reti || (!take && !int_en_clr && (int_en_set || int_enabled));
        if (take) saved_pc <= candidate;
      end
    end
  end

`ifdef FETCH_SEQ_LEVEL_IRQ_EN
  logic [NUM_IRQ-1:0] ack_block;
  assign pending = int_req & ~ack_block;
  always_ff @(posedge clk) begin
    if (reset) ack_block <= '0;
    else ack_block <= (ack_block | clr) & int_req;
  end
`else
  logic [NUM_IRQ-1:0] req_prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      req_prev <= '0;
      pending <= '0;
    end else begin
      req_prev <= int_req;
      pending <= (pending & ~clr) | (int_req & ~req_prev);
    end
  end
`endif
endmodule
